// File: rtl/fifo_beat_packer_if.sv
// Bus bundle for fifo_beat_packer: upstream FIFO read port, flush request,
// packed-beat output channel and a debug view of the FSM state.
interface fifo_beat_packer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PACK_NUM   = 4,
   parameter int LANE_WIDTH = 3
);
   logic                           fifo_empty_i;
   logic [DATA_WIDTH-1:0]          fifo_r_data_i;
   logic                           fifo_r_en_o;
   logic                           flush_i;
   logic                           out_valid_o;
   logic                           out_ready_i;
   logic [PACK_NUM*DATA_WIDTH-1:0] out_data_o;
   logic [PACK_NUM-1:0]            out_mask_o;
   logic [LANE_WIDTH-1:0]          out_count_o;
   logic                           dbg_send;

   // Handshake: a beat transfers on any clock edge where out_valid_o and
   // out_ready_i are both 1; once raised, out_valid_o and the beat stay
   // stable until that edge. A FIFO word is consumed on every edge where
   // fifo_r_en_o is 1. dbg_send is 1 in SEND, 0 in FILL.
   modport master (
      input  fifo_empty_i, fifo_r_data_i, flush_i, out_ready_i,
      output fifo_r_en_o, out_valid_o, out_data_o, out_mask_o, out_count_o,
             dbg_send
   );

   modport slave (
      output fifo_empty_i, fifo_r_data_i, flush_i, out_ready_i,
      input  fifo_r_en_o, out_valid_o, out_data_o, out_mask_o, out_count_o,
             dbg_send
   );
endinterface

// File: rtl/fifo_beat_packer.sv
// Packs PACK_NUM FIFO words into one wide beat; flush_i emits a partial beat.
// Optional idle auto-flush is enabled by defining FIFO_BEAT_PACKER_TIMEOUT_EN.
module fifo_beat_packer #(
   parameter int DATA_WIDTH     = 32,
   parameter int PACK_NUM       = 4,
   parameter int LANE_WIDTH     = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fifo_beat_packer_if.master   bus
);

   typedef enum logic {
      FILL = 1'b0,
      SEND = 1'b1
   } state_t;

   generate
      if (PACK_NUM < 2) begin : g_bad_pack
         $error("PACK_NUM must be at least 2");
      end
      if (LANE_WIDTH < $clog2(PACK_NUM + 1)) begin : g_bad_lane
         $error("LANE_WIDTH too narrow for PACK_NUM");
      end
      if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be at least 2");
      end
   endgenerate

   state_t                         state_q;
   logic [PACK_NUM*DATA_WIDTH-1:0] data_q;
   logic [PACK_NUM-1:0]            mask_q;
   logic [LANE_WIDTH-1:0]          cnt_q;

   logic pop;
   logic last_lane;
   logic auto_flush;
   logic flush_go;

   // Gated by rst_n so the pop strobe is low while reset is held.
   assign pop       = rst_n && (state_q == FILL) && !bus.fifo_empty_i;
   assign last_lane = (cnt_q == LANE_WIDTH'(PACK_NUM - 1));
   assign flush_go  = (bus.flush_i || auto_flush) && ((cnt_q != '0) || pop);

`ifdef FIFO_BEAT_PACKER_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [IDLE_W-1:0] idle_q;
   logic              idle;

   assign idle       = (state_q == FILL) && (cnt_q != '0) && !pop;
   // Fires on the idle cycle whose increment would reach TIMEOUT_CYCLES-1.
   assign auto_flush = idle && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q <= '0;
      end else if (!idle || flush_go) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_q + 1'b1;
      end
   end
`else
   assign auto_flush = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         data_q  <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            FILL: begin
               if (pop) begin
                  for (int i = 0; i < PACK_NUM; i++) begin
                     if (cnt_q == LANE_WIDTH'(i)) begin
                        data_q[i*DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_r_data_i;
                        mask_q[i]                          <= 1'b1;
                     end
                  end
                  cnt_q <= cnt_q + 1'b1;
               end
               if ((pop && last_lane) || flush_go) begin
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (bus.out_ready_i) begin
                  data_q  <= '0;
                  mask_q  <= '0;
                  cnt_q   <= '0;
                  state_q <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign bus.fifo_r_en_o = pop;
   assign bus.out_valid_o = (state_q == SEND);
   assign bus.out_data_o  = data_q;
   assign bus.out_mask_o  = mask_q;
   assign bus.out_count_o = cnt_q;
   assign bus.dbg_send    = (state_q == SEND);

endmodule

// File: tb/tb_fifo_beat_packer.sv
// Self-checking bench for fifo_beat_packer: directed cases, reset cases and a
// randomized run against a word-queue reference model with a beat scoreboard.
module tb_fifo_beat_packer;

   localparam int DW = 32;
   localparam int PN = 4;
   localparam int LW = 3;
   localparam int TO = 16;

   logic clk;
   logic rst_n;

   fifo_beat_packer_if #(.DATA_WIDTH(DW), .PACK_NUM(PN), .LANE_WIDTH(LW)) bus ();

   fifo_beat_packer #(
      .DATA_WIDTH(DW), .PACK_NUM(PN), .LANE_WIDTH(LW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: words accepted into the current beat, and whether the
   // beat is currently being offered downstream.
   logic [DW-1:0]    acc[$];
   bit               m_send;
   int               m_idle;
   logic [PN*DW-1:0] exp_q[$];

   int               valid_cycles;
   logic [PN*DW-1:0] hs_data;
   logic [PN-1:0]    hs_mask;
   logic [LW-1:0]    hs_count;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [PN*DW-1:0] model_data();
      logic [PN*DW-1:0] pk;
      pk = '0;
      for (int i = 0; i < acc.size(); i++) pk[i*DW +: DW] = acc[i];
      return pk;
   endfunction

   function automatic logic [PN-1:0] model_mask();
      return PN'((1 << acc.size()) - 1);
   endfunction

   task automatic model_reset();
      acc.delete();
      m_send = 1'b0;
      m_idle = 0;
   endtask

   task automatic model_advance(input logic e, input logic [DW-1:0] d, input logic f,
                                input logic r);
      if (!m_send) begin
         if (!e) begin
            acc.push_back(d);
            m_idle = 0;
         end else if (acc.size() > 0) begin
            m_idle++;
         end
         if (acc.size() == PN || (f && acc.size() > 0)) begin
            m_send = 1'b1;
            m_idle = 0;
         end
`ifdef FIFO_BEAT_PACKER_TIMEOUT_EN
         else if (acc.size() > 0 && m_idle == TO - 1) begin
            m_send = 1'b1;
            m_idle = 0;
         end
`endif
      end else if (r) begin
         acc.delete();
         m_send = 1'b0;
         m_idle = 0;
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, score
   // any completed handshake, then advance the model across the next edge.
   task automatic step(input logic e, input logic [DW-1:0] d, input logic f, input logic r);
      @(negedge clk);
      bus.fifo_empty_i  = e;
      bus.fifo_r_data_i = d;
      bus.flush_i       = f;
      bus.out_ready_i   = r;
      #1;
      chk("out_valid", bus.out_valid_o, m_send);
      chk("fifo_r_en", bus.fifo_r_en_o, !m_send && !e);
      chk("out_data",  bus.out_data_o,  model_data());
      chk("out_mask",  bus.out_mask_o,  model_mask());
      chk("out_count", bus.out_count_o, acc.size());
      if (bus.out_valid_o) valid_cycles++;
      if (m_send && r) exp_q.push_back(model_data());
      if (bus.out_valid_o && r) begin
         hs_data  = bus.out_data_o;
         hs_mask  = bus.out_mask_o;
         hs_count = bus.out_count_o;
         if (exp_q.size() == 0) chk("beat_unexpected", bus.out_valid_o, 1'b0);
         else chk("beat_scoreboard", bus.out_data_o, exp_q.pop_front());
      end
      model_advance(e, d, f, r);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_valid"}, bus.out_valid_o, 1'b0);
      chk({tag, "_data"},  bus.out_data_o,  '0);
      chk({tag, "_mask"},  bus.out_mask_o,  '0);
      chk({tag, "_count"}, bus.out_count_o, '0);
      chk({tag, "_r_en"},  bus.fifo_r_en_o, 1'b0);
      chk({tag, "_state"}, bus.dbg_send,    1'b0);
   endtask

   // Asserts reset away from the clock edge with a non-empty FIFO, checks
   // outputs asynchronously, then releases into FILL with the FIFO empty.
   task automatic pulse_reset(input string tag);
      @(negedge clk);
      bus.fifo_empty_i = 1'b0;
      bus.flush_i      = 1'b0;
      bus.out_ready_i  = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_outputs_zero(tag);
      model_reset();
      @(negedge clk);
      bus.fifo_empty_i = 1'b1;
      #1 rst_n = 1'b1;
      #1 chk({tag, "_release_state"}, bus.dbg_send, 1'b0);
   endtask

   initial begin
      int first_valid;

      rst_n             = 1'b0;
      bus.fifo_empty_i  = 1'b0;
      bus.fifo_r_data_i = 32'h5A5A_5A5A;
      bus.flush_i       = 1'b0;
      bus.out_ready_i   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      #1 check_outputs_zero("reset");
      bus.fifo_empty_i = 1'b1;
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Full beat, back-to-back pops, always ready.
      valid_cycles = 0;
      step(0, 32'h11, 0, 1);
      step(0, 32'h22, 0, 1);
      step(0, 32'h33, 0, 1);
      step(0, 32'h44, 0, 1);
      step(1, 32'h0,  0, 1);
      step(1, 32'h0,  0, 1);
      chk("full_data",  hs_data,  128'h00000044_00000033_00000022_00000011);
      chk("full_mask",  hs_mask,  4'b1111);
      chk("full_count", hs_count, 3'd4);
      chk("full_valid_cycles", valid_cycles, 1);

      // Backpressure: five stalled cycles with words waiting upstream.
      valid_cycles = 0;
      for (int i = 1; i <= 4; i++) step(0, DW'(i), 0, 0);
      for (int i = 0; i < 5; i++) step(0, 32'hDEAD_BEEF, 0, 0);
      step(0, 32'hDEAD_BEEF, 0, 1);
      step(1, 32'h0, 0, 1);
      chk("bp_data", hs_data, 128'h00000004_00000003_00000002_00000001);
      chk("bp_valid_cycles", valid_cycles, 6);

      // Flush of a two-word partial beat.
      step(0, 32'hA, 0, 0);
      step(0, 32'hB, 0, 0);
      step(1, 32'h0, 1, 0);
      step(1, 32'h0, 0, 1);
      step(1, 32'h0, 0, 1);
      chk("flush_data",  hs_data,  128'h00000000_00000000_0000000B_0000000A);
      chk("flush_mask",  hs_mask,  4'b0011);
      chk("flush_count", hs_count, 3'd2);

      // Flush together with a pop, then a flush with nothing to send.
      step(0, 32'h5, 0, 0);
      step(0, 32'hC, 1, 0);
      step(1, 32'h0, 0, 1);
      chk("flush_pop_count", hs_count, 3'd2);
      chk("flush_pop_lane1", hs_data[DW +: DW], 32'hC);
      valid_cycles = 0;
      step(1, 32'h0, 1, 1);
      step(1, 32'h0, 1, 1);
      step(1, 32'h0, 0, 1);
      chk("empty_flush_no_valid", valid_cycles, 0);

      // Reset while holding a full beat, then while partially filled.
      for (int i = 0; i < 4; i++) step(0, DW'(32'h100 + i), 0, 0);
      step(1, 32'h0, 0, 0);
      chk("pre_reset_send", bus.dbg_send, 1'b1);
      pulse_reset("rst_send");
      step(0, 32'h61, 0, 0);
      step(0, 32'h62, 0, 0);
      pulse_reset("rst_fill");
      step(1, 32'h0, 0, 0);

      // Idle timeout after a single pop.
      first_valid = -1;
      step(0, 32'h77, 0, 0);
      for (int k = 1; k <= 30; k++) begin
         step(1, 32'h0, 0, 0);
         if (bus.out_valid_o && first_valid < 0) first_valid = k;
      end
`ifdef FIFO_BEAT_PACKER_TIMEOUT_EN
      chk("timeout_latency", first_valid, TO);
      chk("timeout_count", bus.out_count_o, 3'd1);
`else
      chk("no_timeout_valid", first_valid, -1);
      step(1, 32'h0, 1, 0);
`endif
      step(1, 32'h0, 0, 1);
      step(1, 32'h0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step(logic'($urandom_range(0, 1)), DW'($urandom),
              logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 9) < 6));
      end
      for (int i = 0; i < 4; i++) step(1, 32'h0, 1, 1);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
